// File: rtl/regfile_wb_writer_if.sv
// Writeback request channels into regfile_wb_writer: single-cycle ALU results and load returns.
// The master drives requests and the slave (the writer) returns per-channel ready.
interface regfile_wb_writer_if;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_reg;
    logic [31:0] ld_data;
    logic        ld_ready;

    modport master (
        output alu_valid, alu_reg, alu_data,
        input  alu_ready,
        output ld_valid, ld_reg, ld_data,
        input  ld_ready
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        output alu_ready,
        input  ld_valid, ld_reg, ld_data,
        output ld_ready
    );
endinterface

// File: rtl/regfile_wb_writer.sv
// Merges ALU results and FIFO-buffered load returns onto the single register-file write port.
// Optional macro REGFILE_WB_ZERO_FILTER_EN suppresses writes to $0 and keeps busy_mask[0] clear.
module regfile_wb_writer #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    regfile_wb_writer_if.slave       wb,
    output logic                     RegWrite,
    output logic [4:0]               WriteReg,
    output logic [31:0]              WriteData,
    output logic [31:0]              busy_mask,
    output logic [$clog2(DEPTH):0]   ld_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DEPTH-1:0]  occupied;
    logic [4:0]        fifo_reg  [DEPTH];
    logic [31:0]       fifo_data [DEPTH];

    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              alu_grant;
    logic              waw_block;
    logic [4:0]        sel_reg;
    logic [31:0]       sel_data;
    logic              write_en;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign full   = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign empty  = (wr_ptr == rd_ptr);

    assign ld_count    = wr_ptr - rd_ptr;
    assign wb.ld_ready = !full;
    assign push        = wb.ld_valid && !full;

    // Per-slot valid bits make the pending-write mask a direct OR over live entries.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i]) begin
                busy_mask[fifo_reg[i]] = 1'b1;
            end
        end
`ifdef REGFILE_WB_ZERO_FILTER_EN
        busy_mask[0] = 1'b0;
`endif
    end

    assign waw_block    = wb.alu_valid && busy_mask[wb.alu_reg];
    assign wb.alu_ready = !full && !waw_block;

    // A full FIFO always drains first, which bounds how long any load can starve.
    always_comb begin
        pop       = 1'b0;
        alu_grant = 1'b0;
        if (full) begin
            pop = 1'b1;
        end else if (waw_block) begin
            pop = 1'b1;
        end else if (wb.alu_valid) begin
            alu_grant = 1'b1;
        end else if (!empty) begin
            pop = 1'b1;
        end
    end

    always_comb begin
        sel_reg  = pop ? fifo_reg[rd_idx]  : wb.alu_reg;
        sel_data = pop ? fifo_data[rd_idx] : wb.alu_data;
`ifdef REGFILE_WB_ZERO_FILTER_EN
        write_en = (pop || alu_grant) && (sel_reg != 5'd0);
`else
        write_en = pop || alu_grant;
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupied  <= '0;
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            RegWrite <= write_en;
            if (write_en) begin
                WriteReg  <= sel_reg;
                WriteData <= sel_data;
            end
            if (pop) begin
                occupied[rd_idx] <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
            if (push) begin
                occupied[wr_idx] <= 1'b1;
                wr_ptr           <= wr_ptr + 1'b1;
            end
        end
    end

    // Payload storage needs no reset; occupancy alone says which slots are meaningful.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_reg[wr_idx]  <= wb.ld_reg;
            fifo_data[wr_idx] <= wb.ld_data;
        end
    end

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Scoreboard bench for regfile_wb_writer: a queue-based reference model predicts every write,
// and a separate monitor checks each RegWrite pulse against the expected queue.
module tb_regfile_wb_writer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        ent_t e;
        int   c;
    } exp_t;

    logic                     clock;
    logic                     reset;
    logic                     RegWrite;
    logic [4:0]               WriteReg;
    logic [31:0]              WriteData;
    logic [31:0]              busy_mask;
    logic [$clog2(DEPTH):0]   ld_count;

    regfile_wb_writer_if bus ();

    regfile_wb_writer #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .wb        (bus),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .busy_mask (busy_mask),
        .ld_count  (ld_count)
    );

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    ent_t mq[$];
    exp_t sb[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit writesReg(input logic [4:0] r);
`ifdef REGFILE_WB_ZERO_FILTER_EN
        return r != 5'd0;
`else
        return 1'b1;
`endif
    endfunction

    // One clock cycle: drive inputs, check combinational outputs against the model, advance the model.
    task automatic applyStimulus(input logic rst_n,
                                 input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                 input logic lv, input logic [4:0] lr, input logic [31:0] ldat,
                                 output logic a_acc, output logic l_acc);
        logic [31:0] mbusy;
        bit          mfull;
        bit          do_pop;
        exp_t        x;
        @(negedge clock);
        reset         = rst_n;
        bus.alu_valid = av;
        bus.alu_reg   = ar;
        bus.alu_data  = ad;
        bus.ld_valid  = lv;
        bus.ld_reg    = lr;
        bus.ld_data   = ldat;
        #1;
        a_acc = 1'b0;
        l_acc = 1'b0;
        if (!rst_n) begin
            mq.delete();
            return;
        end
        mbusy = '0;
        foreach (mq[i]) if (writesReg(mq[i].r)) mbusy[mq[i].r] = 1'b1;
        mfull = (mq.size() == DEPTH);
        do_pop = 1'b0;
        if (mfull) do_pop = 1'b1;
        else if (av && mbusy[ar]) do_pop = 1'b1;
        else if (av) a_acc = 1'b1;
        else if (mq.size() > 0) do_pop = 1'b1;
        l_acc = lv && !mfull;

        checkOutput("alu_ready", 32'(bus.alu_ready), 32'(!mfull && !(av && mbusy[ar])));
        checkOutput("ld_ready",  32'(bus.ld_ready),  32'(!mfull));
        checkOutput("busy_mask", busy_mask, mbusy);
        checkOutput("ld_count",  32'(ld_count), 32'(mq.size()));

        if (do_pop) begin
            x.e = mq.pop_front();
            x.c = cyc + 1;
            if (writesReg(x.e.r)) sb.push_back(x);
        end else if (a_acc) begin
            x.e = '{r: ar, d: ad};
            x.c = cyc + 1;
            if (writesReg(ar)) sb.push_back(x);
        end
        if (l_acc) mq.push_back('{r: lr, d: ldat});
    endtask

    // Monitor: every write must match the oldest expected write, in the predicted cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            cyc++;
            #2;
            if (RegWrite === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_write", 32'(WriteReg), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    checkOutput("WriteReg",  32'(WriteReg), 32'(e.e.r));
                    checkOutput("WriteData", WriteData, e.e.d);
                    checkOutput("write_cycle", 32'(cyc), 32'(e.c));
                end
            end else if (sb.size() > 0 && sb[0].c <= cyc) begin
                e = sb.pop_front();
                checkOutput("missed_write", 32'(RegWrite), 32'd1);
            end
        end
    end

    initial begin
        logic        a, l;
        logic        pa_v, pl_v;
        logic [4:0]  pa_r, pl_r;
        logic [31:0] pa_d, pl_d;
        int          k;
        int          lsent;

        reset = 1'b0;
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
        bus.ld_valid  = 1'b0; bus.ld_reg  = '0; bus.ld_data  = '0;

        // Reset with both requesters active
        repeat (2) applyStimulus(1'b0, 1'b1, 5'd4, 32'h1111, 1'b1, 5'd6, 32'h2222, a, l);
        checkOutput("rst_RegWrite",  32'(RegWrite), 32'd0);
        checkOutput("rst_WriteReg",  32'(WriteReg), 32'd0);
        checkOutput("rst_WriteData", WriteData, 32'd0);
        checkOutput("rst_busy_mask", busy_mask, 32'd0);
        checkOutput("rst_ld_count",  32'(ld_count), 32'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a, l);

        // ALU only
        applyStimulus(1'b1, 1'b1, 5'd5, 32'h0000_0014, 1'b0, 5'd0, 32'd0, a, l);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a, l);

        // Single load while ALU idle
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hDEAD_BEEF, a, l);
        repeat (3) applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a, l);

        // WAW: load r7 then ALU r7 held until accepted
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1, a, l);
        k = 0;
        do begin
            applyStimulus(1'b1, 1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0, a, l);
            k++;
        end while (!a && k < 20);
        checkOutput("waw_alu_accepted", 32'(a), 32'd1);
        repeat (3) applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a, l);

        // Fill the FIFO with five loads while ALU keeps requesting r9
        lsent = 0;
        k = 0;
        while (lsent < 5 && k < 40) begin
            applyStimulus(1'b1, 1'b1, 5'd9, 32'h9000 + 32'(k), 1'b1, 5'(10 + lsent),
                          32'hA000 + 32'(lsent), a, l);
            if (l) lsent++;
            k++;
        end
        checkOutput("full_all_loads_pushed", 32'(lsent), 32'd5);
        repeat (8) applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a, l);

        // Register 0 from both sources
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h0BAD, 1'b1, 5'd0, 32'h0C0D, a, l);
        checkOutput("zero_alu_accepted", 32'(a), 32'd1);
        checkOutput("zero_ld_accepted",  32'(l), 32'd1);
        repeat (3) applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a, l);

        // Randomized traffic with held requests and a mid-run reset
        pa_v = 1'b0; pa_r = '0; pa_d = '0;
        pl_v = 1'b0; pl_r = '0; pl_d = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!pa_v && ($urandom_range(0, 99) < 55)) begin
                pa_v = 1'b1; pa_r = 5'($urandom_range(0, 7)); pa_d = $urandom;
            end
            if (!pl_v && ($urandom_range(0, 99) < 45)) begin
                pl_v = 1'b1; pl_r = 5'($urandom_range(0, 7)); pl_d = $urandom;
            end
            if (i == 700 || i == 701) begin
                applyStimulus(1'b0, pa_v, pa_r, pa_d, pl_v, pl_r, pl_d, a, l);
                pa_v = 1'b0;
                pl_v = 1'b0;
            end else begin
                applyStimulus(1'b1, pa_v, pa_r, pa_d, pl_v, pl_r, pl_d, a, l);
                if (a) pa_v = 1'b0;
                if (l) pl_v = 1'b0;
            end
        end

        repeat (10) applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a, l);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        checkOutput("fifo_drained", 32'(ld_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wb_writer.md
# regfile_wb_writer

Write-side front end for the 32x32 register file. Merges two writeback sources into the register file's single write port: single-cycle ALU results and variable-latency load returns. Load returns are buffered in a small in-order FIFO. Write-after-write order is preserved per destination register, and a pending-write mask is exported for the hazard logic. Sits between the execute/memory stages and the register file write port (RegWrite, WriteReg, WriteData).

## Interface
- DEPTH, 4, load-return FIFO entries; power of two, ≥2
- clock  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-low
- alu_valid  in  1  ALU writeback request
- alu_reg  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU request accepted this cycle (combinational)
- ld_valid  in  1  load-return request
- ld_reg  in  5  load destination register
- ld_data  in  32  loaded word
- ld_ready  out  1  FIFO can accept (combinational, = !full)
- RegWrite  out  1  register-file write enable (registered)
- WriteReg  out  5  register-file write address (registered)
- WriteData  out  32  register-file write data (registered)
- busy_mask  out  32  bit i = 1 while any FIFO entry targets register i (combinational from FIFO state)
- ld_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- FIFO: circular, wr_ptr/rd_ptr with an extra wrap bit; full = pointers equal except the wrap bit; empty = pointers fully equal.
- Load push occurs when ld_valid && ld_ready. Loads always pass through the FIFO; there is no bypass.
- Exactly one write-port grant per cycle, in this priority order:
  1. FIFO full: pop FIFO; alu_ready = 0.
  2. alu_valid && busy_mask[alu_reg] (WAW conflict with a queued load): pop FIFO; alu_ready = 0.
  3. alu_valid: issue ALU write; alu_ready = 1.
  4. FIFO non-empty: pop FIFO.
  5. Idle: RegWrite <= 0.
- When alu_valid = 0, alu_ready is still 1 unless case 1 applies.
- A push and a pop may occur in the same cycle. This is only possible when the FIFO is not full; occupancy is then unchanged.
- Data width: 32-bit passthrough, no modification. WriteReg and WriteData hold their last values when RegWrite = 0.
- busy_mask is the OR over valid entries of the one-hot encoding of reg. Multiple entries for the same register keep the bit set until the last of them pops.

## Timing
- Reset (reset = 0 at a clock edge): RegWrite = 0, WriteReg = 0, WriteData = 0, FIFO emptied, busy_mask = 0, ld_count = 0. A reset asserted mid-operation discards queued loads.
- ALU latency: accepted in cycle N -> RegWrite = 1 with that data in cycle N+1.
- Load latency: pushed in cycle N -> earliest write in cycle N+2 (popped in N+1, output registered).
- Sustained throughput: one register-file write per cycle.
- Load starvation bound: the FIFO drains whenever it is full, so no load waits more than DEPTH grant cycles after the FIFO fills.
- The register file samples the outputs on the next edge. Register visibility is therefore 2 cycles after ALU acceptance and ≥3 cycles after load push.

## Configuration
- REGFILE_WB_ZERO_FILTER_EN defined:
  - A request whose destination is register 0 is accepted normally (handshake, FIFO slot, arbitration).
  - At grant, RegWrite stays 0, so $0 is never written.
  - Register 0 never sets busy_mask[0].
- REGFILE_WB_ZERO_FILTER_EN undefined: register 0 is treated like every other register. RegWrite = 1 for its writes, and busy_mask[0] behaves normally.

## Test plan
- Reset: drive reset = 0 for 2 cycles with ld_valid = alu_valid = 1 -> RegWrite = 0, busy_mask = 0, ld_count = 0. After release, FIFO empty and ld_ready = 1.
- ALU only: alu_valid with reg 5, data 0x0000_0014, in cycle N -> cycle N+1 shows RegWrite = 1, WriteReg = 5, WriteData = 0x14, with alu_ready = 1 throughout.
- Load through FIFO while ALU idle: push reg 3 / 0xDEAD_BEEF in N -> write appears in N+2, busy_mask[3] = 1 during N+1 only, ld_count returns to 0.
- WAW ordering: push load reg 7 = 0x1, then ALU reg 7 = 0x2 the next cycle -> alu_ready = 0 until the load pops. Writes are observed in order 0x1 then 0x2.
- Full priority with DEPTH = 4: fill with 4 loads while alu_valid is held on reg 9 -> ld_ready = 0 and alu_ready = 0 on the full cycle, the FIFO pops first, and no load is lost or duplicated.
- Zero filter: with REGFILE_WB_ZERO_FILTER_EN, ALU to reg 0 and load to reg 0 are both accepted, RegWrite never asserts, busy_mask[0] = 0. Without the macro, both writes appear with WriteReg = 0.
